// File: rtl/pipe_regfile_pkg.sv
// -----------------------------------------------------------------------------
// pipe_regfile_pkg
// Shared types and constants for the pipelined-core register file:
//   - state_e      : sweep engine states (ST_IDLE, ST_SWEEP)
//   - DEF_DATA_W   : default register width
//   - DEF_ADDR_W   : default address width
//   - slice_lsb()  : LSB position of port k inside a flattened port bus
// -----------------------------------------------------------------------------
package pipe_regfile_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Bit offset of port 'port' in a bus of 'width'-bit fields packed LSB-first.
    function automatic int unsigned slice_lsb(input int unsigned port,
                                              input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Pending-write scoreboard for the register file. One bit per register,
// set by an issue-stage claim and cleared by the matching writeback, a
// pipeline flush or the start of a zeroing sweep. Produces per-read-port
// stall flags.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_sweep             sweep engine is active (claims/writes ignored, no stalls)
//   i_clear_start       sweep accepted this cycle (clears all pending)
//   i_wr_en, i_wr_addr  writeback port
//   i_claim_en/_addr    issue-stage claim
//   i_flush             pipeline flush (clears all pending)
//   i_rd_addr           flattened read addresses
//   o_rd_busy           per-port stall flags (combinational)
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import pipe_regfile_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NUM_RD  = 2,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_sweep,
    input  logic                     i_clear_start,
    input  logic                     i_wr_en,
    input  logic [ADDR_W-1:0]        i_wr_addr,
    input  logic                     i_claim_en,
    input  logic [ADDR_W-1:0]        i_claim_addr,
    input  logic                     i_flush,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD-1:0]        o_rd_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] r_pending;
    logic [DEPTH-1:0] w_pend_nxt;
    logic             w_wr_ok;
    logic             w_claim_ok;

    assign w_wr_ok    = i_wr_en && !i_sweep &&
                        !(ZERO_R0 && (i_wr_addr == {ADDR_W{1'b0}}));
    assign w_claim_ok = i_claim_en && !i_sweep &&
                        !(ZERO_R0 && (i_claim_addr == {ADDR_W{1'b0}}));

    // Next pending vector: write clears first so a same-cycle claim wins.
    always_comb begin
        w_pend_nxt = r_pending;
        if (i_flush || i_clear_start) begin
            w_pend_nxt = {DEPTH{1'b0}};
        end else begin
            if (w_wr_ok) begin
                w_pend_nxt[i_wr_addr] = 1'b0;
            end else begin
                w_pend_nxt = w_pend_nxt;
            end
            if (w_claim_ok) begin
                w_pend_nxt[i_claim_addr] = 1'b1;
            end else begin
                w_pend_nxt = w_pend_nxt;
            end
        end
    end

    // Pending register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending <= {DEPTH{1'b0}};
        end else begin
            r_pending <= w_pend_nxt;
        end
    end

    // Stall flags: a write to the same register this cycle resolves the
    // hazard through the bypass, so it does not stall.
    always_comb begin
        o_rd_busy = {NUM_RD{1'b0}};
        for (int k = 0; k < NUM_RD; k++) begin
            if (i_sweep) begin
                o_rd_busy[k] = 1'b0;
            end else if (ZERO_R0 &&
                         (i_rd_addr[slice_lsb(k, ADDR_W) +: ADDR_W] == {ADDR_W{1'b0}})) begin
                o_rd_busy[k] = 1'b0;
            end else begin
                o_rd_busy[k] = r_pending[i_rd_addr[slice_lsb(k, ADDR_W) +: ADDR_W]] &&
                               !(i_wr_en &&
                                 (i_wr_addr == i_rd_addr[slice_lsb(k, ADDR_W) +: ADDR_W]));
            end
        end
    end

endmodule

// File: rtl/pipe_regfile.sv
// -----------------------------------------------------------------------------
// pipe_regfile
// Register file for the pipelined core: NUM_RD combinational read ports with
// write-to-read bypass, one edge-committed write port, optional hard-wired
// zero in entry 0, a pending-write scoreboard and a multi-cycle zeroing sweep.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_rd_addr / o_rd_data   flattened read ports (port k at k*ADDR_W / k*DATA_W)
//   o_rd_busy               per-port outstanding-write stall
//   i_wr_en/_addr/_data     writeback port
//   i_claim_en/_addr        issue-stage claim
//   i_flush                 clear all pending bits
//   i_clear_req             start a zeroing sweep
//   o_clear_busy            sweep in progress
// -----------------------------------------------------------------------------
module pipe_regfile
    import pipe_regfile_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NUM_RD  = 2,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    output logic [NUM_RD-1:0]        o_rd_busy,
    input  logic                     i_wr_en,
    input  logic [ADDR_W-1:0]        i_wr_addr,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_claim_en,
    input  logic [ADDR_W-1:0]        i_claim_addr,
    input  logic                     i_flush,
    input  logic                     i_clear_req,
    output logic                     o_clear_busy
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    logic [DATA_W-1:0] r_mem [DEPTH];
    state_e            r_state;
    logic [ADDR_W-1:0] r_idx;
    logic              r_clear_busy;

    logic w_sweep;
    logic w_clear_start;
    logic w_wr_ok;

    assign w_sweep       = (r_state == ST_SWEEP);
    assign w_clear_start = (r_state == ST_IDLE) && i_clear_req;
    assign w_wr_ok       = i_wr_en && !w_sweep &&
                           !(ZERO_R0 && (i_wr_addr == {ADDR_W{1'b0}}));
    assign o_clear_busy  = r_clear_busy;

    // Sweep FSM: index walks 0..DEPTH-1, one entry per cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= {ADDR_W{1'b0}};
            r_clear_busy <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_clear_req) begin
                        r_state      <= ST_SWEEP;
                        r_idx        <= {ADDR_W{1'b0}};
                        r_clear_busy <= 1'b1;
                    end else begin
                        r_state      <= ST_IDLE;
                        r_clear_busy <= 1'b0;
                    end
                end
                ST_SWEEP: begin
                    if (r_idx == LAST_IDX) begin
                        r_state      <= ST_IDLE;
                        r_idx        <= {ADDR_W{1'b0}};
                        r_clear_busy <= 1'b0;
                    end else begin
                        r_idx        <= r_idx + {{(ADDR_W-1){1'b0}}, 1'b1};
                        r_clear_busy <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_idx        <= {ADDR_W{1'b0}};
                    r_clear_busy <= 1'b0;
                end
            endcase
        end
    end

    // Data array: reset and sweep zero entries; writes only land in IDLE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
        end else if (w_sweep) begin
            r_mem[r_idx] <= {DATA_W{1'b0}};
        end else if (w_wr_ok) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end else begin
            r_mem[0] <= r_mem[0];
        end
    end

    // Read muxes: zero register, then same-cycle bypass (IDLE only), then array.
    always_comb begin
        o_rd_data = {(NUM_RD*DATA_W){1'b0}};
        for (int k = 0; k < NUM_RD; k++) begin
            if (ZERO_R0 &&
                (i_rd_addr[slice_lsb(k, ADDR_W) +: ADDR_W] == {ADDR_W{1'b0}})) begin
                o_rd_data[slice_lsb(k, DATA_W) +: DATA_W] = {DATA_W{1'b0}};
            end else if (i_wr_en && !w_sweep &&
                         (i_wr_addr == i_rd_addr[slice_lsb(k, ADDR_W) +: ADDR_W])) begin
                o_rd_data[slice_lsb(k, DATA_W) +: DATA_W] = i_wr_data;
            end else begin
                o_rd_data[slice_lsb(k, DATA_W) +: DATA_W] =
                    r_mem[i_rd_addr[slice_lsb(k, ADDR_W) +: ADDR_W]];
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W  (ADDR_W),
        .NUM_RD  (NUM_RD),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_sweep       (w_sweep),
        .i_clear_start (w_clear_start),
        .i_wr_en       (i_wr_en),
        .i_wr_addr     (i_wr_addr),
        .i_claim_en    (i_claim_en),
        .i_claim_addr  (i_claim_addr),
        .i_flush       (i_flush),
        .i_rd_addr     (i_rd_addr),
        .o_rd_busy     (o_rd_busy)
    );

endmodule

// File: tb/tb_pipe_regfile.sv
// -----------------------------------------------------------------------------
// tb_pipe_regfile
// Directed self-checking bench for pipe_regfile (default parameters:
// DATA_W=32, ADDR_W=5, NUM_RD=2, ZERO_R0=1). Inputs change on the falling
// edge; outputs are sampled 1 ns later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_pipe_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr0, rd_addr1;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [31:0] rd_data0, rd_data1;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        claim_en;
    logic [4:0]  claim_addr;
    logic        flush;
    logic        clear_req;
    logic        clear_busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    assign rd_addr  = {rd_addr1, rd_addr0};
    assign rd_data0 = rd_data[31:0];
    assign rd_data1 = rd_data[63:32];

    always #5 clk = ~clk;

    pipe_regfile dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rd_addr    (rd_addr),
        .o_rd_data    (rd_data),
        .o_rd_busy    (rd_busy),
        .i_wr_en      (wr_en),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .i_claim_en   (claim_en),
        .i_claim_addr (claim_addr),
        .i_flush      (flush),
        .i_clear_req  (clear_req),
        .o_clear_busy (clear_busy)
    );

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
        claim_en = 1'b0; claim_addr = 5'd0; flush = 1'b0; clear_req = 1'b0;
        rd_addr0 = 5'd0; rd_addr1 = 5'd5;
        next_cycle(); next_cycle();
        rst = 1'b0;
        #1;
        vec_cnt++;
        if (clear_busy !== 1'b0) begin
            err_cnt++; $display("FAIL reset_clear_busy: got %b want 0", clear_busy);
        end
        vec_cnt++;
        if (rd_busy !== 2'b00) begin
            err_cnt++; $display("FAIL reset_rd_busy: got %b want 00", rd_busy);
        end
        vec_cnt++;
        if (rd_data !== 64'd0) begin
            err_cnt++; $display("FAIL reset_rd_data: got %h want 0", rd_data);
        end
    endtask

    task automatic test_bypass();
        next_cycle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        rd_addr0 = 5'd5; rd_addr1 = 5'd3;
        #1;
        vec_cnt++;
        if (rd_data0 !== 32'hDEADBEEF) begin
            err_cnt++; $display("FAIL bypass_same_cycle: got %h want deadbeef", rd_data0);
        end
        vec_cnt++;
        if (rd_data1 !== 32'd0) begin
            err_cnt++; $display("FAIL bypass_other_port: got %h want 0", rd_data1);
        end
        next_cycle();
        wr_en = 1'b0; wr_data = 32'd0;
        #1;
        vec_cnt++;
        if (rd_data0 !== 32'hDEADBEEF) begin
            err_cnt++; $display("FAIL bypass_array: got %h want deadbeef", rd_data0);
        end
    endtask

    task automatic test_zero_r0();
        next_cycle();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        claim_en = 1'b1; claim_addr = 5'd0; rd_addr0 = 5'd0;
        #1;
        vec_cnt++;
        if (rd_data0 !== 32'd0) begin
            err_cnt++; $display("FAIL r0_bypass: got %h want 0", rd_data0);
        end
        next_cycle();
        wr_en = 1'b0; claim_en = 1'b0;
        #1;
        vec_cnt++;
        if (rd_data0 !== 32'd0 || rd_busy[0] !== 1'b0) begin
            err_cnt++; $display("FAIL r0_after: got data %h busy %b want 0/0", rd_data0, rd_busy[0]);
        end
    endtask

    task automatic test_claim();
        next_cycle();
        claim_en = 1'b1; claim_addr = 5'd7; rd_addr1 = 5'd7;
        #1;
        vec_cnt++;
        if (rd_busy[1] !== 1'b0) begin
            err_cnt++; $display("FAIL claim_before_edge: got %b want 0", rd_busy[1]);
        end
        next_cycle();
        claim_en = 1'b0;
        #1;
        vec_cnt++;
        if (rd_busy[1] !== 1'b1) begin
            err_cnt++; $display("FAIL claim_n1: got %b want 1", rd_busy[1]);
        end
        next_cycle();
        #1;
        vec_cnt++;
        if (rd_busy[1] !== 1'b1) begin
            err_cnt++; $display("FAIL claim_n2: got %b want 1", rd_busy[1]);
        end
        next_cycle();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
        #1;
        vec_cnt++;
        if (rd_busy[1] !== 1'b0 || rd_data1 !== 32'h55) begin
            err_cnt++; $display("FAIL claim_write: got busy %b data %h want 0/55", rd_busy[1], rd_data1);
        end
        next_cycle();
        wr_en = 1'b0;
        #1;
        vec_cnt++;
        if (rd_busy[1] !== 1'b0 || rd_data1 !== 32'h55) begin
            err_cnt++; $display("FAIL claim_after: got busy %b data %h want 0/55", rd_busy[1], rd_data1);
        end
    endtask

    task automatic test_claim_write_flush();
        next_cycle();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hAA;
        claim_en = 1'b1; claim_addr = 5'd9; rd_addr0 = 5'd9;
        next_cycle();
        wr_en = 1'b0; claim_en = 1'b0;
        #1;
        vec_cnt++;
        if (rd_data0 !== 32'hAA || rd_busy[0] !== 1'b1) begin
            err_cnt++; $display("FAIL claim_write_same: got data %h busy %b want aa/1", rd_data0, rd_busy[0]);
        end
        // flush and a claim on the same register together: flush wins
        flush = 1'b1; claim_en = 1'b1; claim_addr = 5'd9;
        next_cycle();
        flush = 1'b0; claim_en = 1'b0;
        #1;
        vec_cnt++;
        if (rd_busy[0] !== 1'b0) begin
            err_cnt++; $display("FAIL flush: got %b want 0", rd_busy[0]);
        end
    endtask

    task automatic test_sweep();
        int cnt;
        int guard;
        int bad;
        for (int i = 1; i < 32; i++) begin
            next_cycle();
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i);
        end
        next_cycle();
        wr_en = 1'b0;
        claim_en = 1'b1; claim_addr = 5'd3;
        next_cycle();
        claim_en = 1'b0;
        clear_req = 1'b1; rd_addr0 = 5'd1; rd_addr1 = 5'd3;
        #1;
        vec_cnt++;
        if (clear_busy !== 1'b0 || rd_busy[1] !== 1'b1 || rd_data1 !== 32'd3) begin
            err_cnt++; $display("FAIL sweep_pre: got cb %b busy %b data %h want 0/1/3", clear_busy, rd_busy[1], rd_data1);
        end
        next_cycle();
        clear_req = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'hFFFFFFFF;
        claim_en = 1'b1; claim_addr = 5'd3;
        #1;
        vec_cnt++;
        if (rd_data0 !== 32'd1 || rd_busy[1] !== 1'b0) begin
            err_cnt++; $display("FAIL sweep_first: got data %h busy %b want 1/0", rd_data0, rd_busy[1]);
        end
        cnt = 0; guard = 0;
        while (clear_busy === 1'b1 && guard < 100) begin
            cnt++; guard++;
            next_cycle();
            #1;
        end
        wr_en = 1'b0; claim_en = 1'b0;
        vec_cnt++;
        if (cnt != 32) begin
            err_cnt++; $display("FAIL sweep_len: got %0d cycles want 32", cnt);
        end
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            next_cycle();
            rd_addr0 = 5'(i); rd_addr1 = 5'(31 - i);
            #1;
            if (rd_data !== 64'd0 || rd_busy !== 2'b00) begin
                bad++;
                $display("FAIL sweep_contents: addr %0d got data %h busy %b want 0/00", i, rd_data, rd_busy);
            end
        end
        vec_cnt++;
        if (bad != 0) err_cnt++;
    endtask

    task automatic test_reset_mid_sweep();
        next_cycle();
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'h77;
        next_cycle();
        wr_en = 1'b0; clear_req = 1'b1;
        next_cycle();
        clear_req = 1'b0;
        for (int i = 0; i < 10; i++) next_cycle();
        rd_addr0 = 5'd20; rd_addr1 = 5'd1;
        #1;
        vec_cnt++;
        if (clear_busy !== 1'b1 || rd_data0 !== 32'h77) begin
            err_cnt++; $display("FAIL mid_sweep: got cb %b r20 %h want 1/77", clear_busy, rd_data0);
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        vec_cnt++;
        if (clear_busy !== 1'b0 || rd_data !== 64'd0) begin
            err_cnt++; $display("FAIL rst_mid_sweep: got cb %b data %h want 0/0", clear_busy, rd_data);
        end
        // Back in IDLE: a write is bypassed now and held by the array next cycle.
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h66;
        #1;
        vec_cnt++;
        if (rd_data1 !== 32'h66) begin
            err_cnt++; $display("FAIL idle_after_rst_bypass: got %h want 66", rd_data1);
        end
        next_cycle();
        wr_en = 1'b0;
        #1;
        vec_cnt++;
        if (rd_data1 !== 32'h66 || clear_busy !== 1'b0) begin
            err_cnt++; $display("FAIL idle_after_rst_array: got %h cb %b want 66/0", rd_data1, clear_busy);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_zero_r0();
        test_claim();
        test_claim_write_flush();
        test_sweep();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
